// File: rtl/uart_axil_ctrl.sv
// AXI4-Lite slave front end for the UART core: maps Rx/Tx FIFOs, status and
// control into four 32-bit registers, with sticky error flags and a level irq.
module uart_axil_ctrl #(
    parameter int DBITS  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic [DBITS-1:0]  read_data,
    input  logic              rx_empty,
    input  logic              rx_full,
    input  logic              tx_full,
    output logic              read_uart,
    output logic              write_uart,
    output logic [DBITS-1:0]  write_data,
    output logic              irq
);
    localparam logic [1:0] A_RXDATA = 2'd0;
    localparam logic [1:0] A_TXDATA = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;

    typedef struct packed {
        logic [1:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_req_t;

    r_state_t    r_state;
    w_state_t    w_state;
    wr_req_t     wreq;
    logic        aw_held, w_held;
    logic [1:0]  ctrl;
    logic        tx_ovf, rx_unf;
    logic [31:0] rx_word, rd_mux;

    logic [1:0] rd_sel;
    logic       ar_hs, aw_hs, w_hs, aw_have, w_have, exec;
    logic       wr_txdata, tx_ovf_set, rx_unf_set, st_wr, ovf_clr, unf_clr, ctrl_wr;

    assign rd_sel  = s_axi_araddr[3:2];
    assign ar_hs   = s_axi_arvalid & s_axi_arready;
    assign aw_hs   = s_axi_awvalid & s_axi_awready;
    assign w_hs    = s_axi_wvalid & s_axi_wready;
    assign aw_have = aw_held | aw_hs;
    assign w_have  = w_held | w_hs;

    // Strobes are combinational, so gate them with reset to keep them quiet
    // in the cycle reset is first seen.
    assign read_uart  = ~reset & ar_hs & (rd_sel == A_RXDATA) & ~rx_empty;
    assign exec       = ~reset & (w_state == W_EXEC);
    assign wr_txdata  = exec & (wreq.addr == A_TXDATA) & wreq.strb[0];
    assign write_uart = wr_txdata & ~tx_full;
    assign write_data = write_uart ? wreq.data[DBITS-1:0] : '0;

    assign tx_ovf_set = wr_txdata & tx_full;
    assign rx_unf_set = ar_hs & (rd_sel == A_RXDATA) & rx_empty;
    assign st_wr      = exec & (wreq.addr == A_STATUS) & wreq.strb[0];
    assign ovf_clr    = st_wr & wreq.data[3];
    assign unf_clr    = st_wr & wreq.data[4];
    assign ctrl_wr    = exec & (wreq.addr == A_CTRL) & wreq.strb[0];

    always_comb begin
        rx_word = '0;
        rx_word[DBITS-1:0] = read_data;
    end

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            A_RXDATA: rd_mux = rx_empty ? 32'h8000_0000 : rx_word;
            A_TXDATA: rd_mux = '0;
            A_STATUS: rd_mux = 32'({rx_unf, tx_ovf, tx_full, rx_full, rx_empty});
            A_CTRL:   rd_mux = 32'(ctrl);
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (ar_hs) begin
                        r_state       <= R_DATA;
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rdata   <= rd_mux;
                        s_axi_rresp   <= RESP_OKAY;
                    end
                end
                R_DATA: begin
                    if (s_axi_rvalid & s_axi_rready) begin
                        r_state       <= R_IDLE;
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // AW and W are latched independently; EXEC fires once both are held.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            w_state       <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            wreq          <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    s_axi_awready <= ~aw_have;
                    s_axi_wready  <= ~w_have;
                    if (aw_hs) begin
                        aw_held   <= 1'b1;
                        wreq.addr <= s_axi_awaddr[3:2];
                    end
                    if (w_hs) begin
                        w_held    <= 1'b1;
                        wreq.data <= s_axi_wdata;
                        wreq.strb <= s_axi_wstrb;
                    end
                    if (aw_have & w_have)
                        w_state <= W_EXEC;
                end
                W_EXEC: begin
                    w_state      <= W_RESP;
                    s_axi_bvalid <= 1'b1;
                    s_axi_bresp  <= RESP_OKAY;
                end
                W_RESP: begin
                    if (s_axi_bvalid & s_axi_bready) begin
                        w_state       <= W_IDLE;
                        s_axi_bvalid  <= 1'b0;
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Set beats W1C when both land on the same edge.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            ctrl   <= '0;
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
            irq    <= 1'b0;
        end else begin
            tx_ovf <= tx_ovf_set | (tx_ovf & ~ovf_clr);
            rx_unf <= rx_unf_set | (rx_unf & ~unf_clr);
            if (ctrl_wr)
                ctrl <= wreq.data[1:0];
            irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_ovf);
        end
    end

    logic unused_ok;
    assign unused_ok = ^{s_axi_awaddr, s_axi_araddr, wreq.data, wreq.strb};

endmodule

// File: tb/tb_uart_axil_ctrl.sv
// Directed bench for uart_axil_ctrl: register-level model of FIFOs, stickies
// and CTRL, checked every cycle by one monitor, plus literal expectations.
module tb_uart_axil_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [7:0]  rd_i = '0;
    logic        rxe_i = 1'b1, rxf_i = 1'b0, tx_full_i = 1'b0;
    logic        read_uart, write_uart, irq;
    logic [7:0]  write_data;

    int checks = 0, errors = 0;
    int pops = 0, tx_pushes = 0;
    logic [7:0] rxq[$];

    uart_axil_ctrl #(.DBITS(8), .ADDR_W(4)) dut (
        .clk_100MHz(clk), .reset(reset),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .read_data(rd_i), .rx_empty(rxe_i), .rx_full(rxf_i), .tx_full(tx_full_i),
        .read_uart(read_uart), .write_uart(write_uart), .write_data(write_data), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", nm);
    endtask

    task automatic rx_refresh();
        rxe_i = (rxq.size() == 0);
        rxf_i = (rxq.size() >= 4);
        rd_i  = (rxq.size() != 0) ? rxq[0] : 8'h00;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rxq.push_back(b);
        rx_refresh();
    endtask

    // Model: stickies, CTRL, pending read data, write capture and EXEC timing.
    logic        m_unf = 0, m_ovf = 0, m_aw_got = 0, m_w_got = 0, m_both = 0, m_exec = 0;
    logic [1:0]  m_ctrl = 0, m_waddr = 0;
    logic [31:0] m_wdata = 0;
    logic [3:0]  m_wstrb = 0;
    logic [31:0] exp_r[$];
    logic        exp_irq = 0, bv_prev = 0;
    int          cyc = 0, both_cyc = 0;

    initial begin
        logic pop, push, exp_irq_n, ar_hs, unf_set, ovf_set, ovf_clr, unf_clr, nb;
        logic [31:0] v;
        forever begin
            @(negedge clk); #1;
            cyc++;
            pop = 0;
            exp_irq_n = 0;
            if (reset) begin
                chk("read_uart_in_reset", read_uart, 1'b0);
                chk("write_uart_in_reset", write_uart, 1'b0);
                m_unf = 0; m_ovf = 0; m_ctrl = 0; m_aw_got = 0; m_w_got = 0;
                m_both = 0; m_exec = 0; bv_prev = 0;
                exp_r.delete();
            end else begin
                chk("irq", irq, exp_irq);
                ar_hs = arvalid && arready;
                pop = ar_hs && araddr[3:2] == 2'd0 && rxq.size() != 0;
                chk("read_uart", read_uart, pop);
                if (pop) pops++;
                push = m_exec && m_waddr == 2'd1 && m_wstrb[0] && !tx_full_i;
                chk("write_uart", write_uart, push);
                if (push) begin
                    chk("write_data", write_data, m_wdata[7:0]);
                    tx_pushes++;
                end
                if (rvalid && rready) begin
                    if (exp_r.size() == 0) fail_to("unexpected_rvalid");
                    else chk("rdata", rdata, exp_r.pop_front());
                    chk("rresp", rresp, 2'b00);
                end
                if (bvalid && !bv_prev) chk("bvalid_latency", 32'(cyc - both_cyc), 32'd2);
                bv_prev = bvalid;
                exp_irq_n = (m_ctrl[0] && rxq.size() != 0) || (m_ctrl[1] && m_ovf);
                unf_set = ar_hs && araddr[3:2] == 2'd0 && rxq.size() == 0;
                if (ar_hs) begin
                    case (araddr[3:2])
                        2'd0:    v = (rxq.size() != 0) ? {24'h0, rxq[0]} : 32'h8000_0000;
                        2'd1:    v = 32'h0;
                        2'd2:    v = {27'h0, m_unf, m_ovf, tx_full_i, rxf_i, rxq.size() == 0};
                        default: v = {30'h0, m_ctrl};
                    endcase
                    exp_r.push_back(v);
                end
                ovf_set = m_exec && m_waddr == 2'd1 && m_wstrb[0] && tx_full_i;
                ovf_clr = m_exec && m_waddr == 2'd2 && m_wstrb[0] && m_wdata[3];
                unf_clr = m_exec && m_waddr == 2'd2 && m_wstrb[0] && m_wdata[4];
                if (m_exec && m_waddr == 2'd3 && m_wstrb[0]) m_ctrl = m_wdata[1:0];
                m_ovf = ovf_set || (m_ovf && !ovf_clr);
                m_unf = unf_set || (m_unf && !unf_clr);
                if (bvalid && bready) begin
                    chk("bresp", bresp, 2'b00);
                    m_aw_got = 0; m_w_got = 0; m_both = 0;
                end
                if (awvalid && awready) begin m_aw_got = 1; m_waddr = awaddr[3:2]; end
                if (wvalid && wready) begin m_w_got = 1; m_wdata = wdata; m_wstrb = wstrb; end
                nb = m_aw_got && m_w_got && !m_both;
                if (nb) begin m_both = 1; both_cyc = cyc; end
                m_exec = nb;
            end
            @(posedge clk); #1;
            if (pop) begin void'(rxq.pop_front()); rx_refresh(); end
            exp_irq = exp_irq_n;
        end
    end

    task automatic axi_read(input logic [3:0] a, input int bp, output logic [31:0] d);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1; rready = (bp == 0);
        n = 0;
        while (!arready && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) fail_to("ar_wait");
        @(negedge clk);
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) fail_to("r_wait");
        d = rdata;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_rvalid", rvalid, 1'b1);
            chk("bp_rdata", rdata, d);
            chk("bp_arready", arready, 1'b0);
        end
        rready = 1;
        @(negedge clk);
        rready = 0;
    endtask

    // order: 0 = AW/W together, 1 = W one cycle before AW, 2 = AW before W
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int order, input int bp, output logic [1:0] resp);
        int n;
        logic aw_done, w_done, aw_h, w_h;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; bready = (bp == 0);
        awvalid = (order != 1); wvalid = (order != 2);
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 40) begin
            aw_h = awvalid && awready;
            w_h  = wvalid && wready;
            @(negedge clk); n++;
            if (aw_h) begin awvalid = 0; aw_done = 1; end
            if (w_h)  begin wvalid = 0; w_done = 1; end
            if (!aw_done && !awvalid) awvalid = 1;
            if (!w_done && !wvalid) wvalid = 1;
        end
        if (n >= 40) fail_to("aw_w_wait");
        n = 0;
        while (!bvalid && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) fail_to("b_wait");
        resp = bresp;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_bvalid", bvalid, 1'b1);
            chk("bp_awready", awready, 1'b0);
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_arready"}, arready, 1'b0);
        chk({tag, "_awready"}, awready, 1'b0);
        chk({tag, "_wready"}, wready, 1'b0);
        chk({tag, "_rvalid"}, rvalid, 1'b0);
        chk({tag, "_bvalid"}, bvalid, 1'b0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_resps"}, {28'h0, rresp, bresp}, 32'h0);
        chk({tag, "_write_data"}, write_data, 8'h00);
        chk({tag, "_irq"}, irq, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] d, d2;
        logic [1:0]  r, r2;
        int p0;
        rx_refresh();
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 0;

        // Rx pop, then underflow
        rx_push(8'hA5); rx_push(8'h3C);
        p0 = pops;
        axi_read(4'h0, 0, d); chk("rx_first", d, 32'h0000_00A5);
        axi_read(4'h0, 0, d); chk("rx_second", d, 32'h0000_003C);
        axi_read(4'h0, 0, d); chk("rx_empty_read", d, 32'h8000_0000);
        chk("pop_count", 32'(pops - p0), 32'd2);
        axi_read(4'h8, 0, d); chk("status_unf", d, 32'h0000_0011);
        axi_write(4'h8, 32'h10, 4'h1, 0, 0, r);
        axi_read(4'h8, 0, d); chk("status_unf_clr", d, 32'h0000_0001);

        // Tx push with both channel orderings
        p0 = tx_pushes;
        axi_write(4'h4, 32'h55, 4'h1, 1, 0, r); chk("bresp_w_first", r, 2'b00);
        axi_write(4'h4, 32'h55, 4'h1, 0, 0, r); chk("bresp_same", r, 2'b00);
        chk("tx_push_count", 32'(tx_pushes - p0), 32'd2);
        axi_write(4'h4, 32'h77, 4'h0, 2, 0, r);
        chk("tx_strb0_nopush", 32'(tx_pushes - p0), 32'd2);
        axi_read(4'h4, 0, d); chk("txdata_reads_0", d, 32'h0);

        // Overflow and its interrupt
        tx_full_i = 1;
        axi_write(4'h4, 32'h12, 4'h1, 2, 0, r);
        chk("ovf_nopush", 32'(tx_pushes - p0), 32'd2);
        axi_read(4'h8, 0, d); chk("status_ovf_empty", d, 32'h0000_000D);
        rx_push(8'h77);
        axi_read(4'h8, 0, d); chk("status_ovf", d, 32'h0000_000C);
        axi_write(4'hC, 32'h2, 4'h1, 0, 0, r);
        chk("irq_ovf_on", irq, 1'b1);
        axi_read(4'hE, 0, d); chk("ctrl_low_bits_ignored", d, 32'h2);
        axi_write(4'h8, 32'h8, 4'h0, 0, 0, r);
        axi_read(4'h8, 0, d); chk("status_w1c_strb0", d, 32'h0000_000C);
        axi_write(4'h8, 32'h8, 4'h1, 0, 0, r);
        axi_read(4'h8, 0, d); chk("status_w1c", d, 32'h0000_0004);
        chk("irq_ovf_off", irq, 1'b0);
        tx_full_i = 0;

        // Rx interrupt
        axi_read(4'h0, 0, d); chk("rx_77", d, 32'h77);
        axi_write(4'hC, 32'h1, 4'h1, 0, 0, r);
        chk("irq_rx_idle", irq, 1'b0);
        @(negedge clk); rx_push(8'h9A);
        @(negedge clk); chk("irq_rx_on", irq, 1'b1);
        axi_read(4'h0, 0, d); chk("rx_9a", d, 32'h9A);
        chk("irq_rx_off", irq, 1'b0);

        // Backpressure
        rx_push(8'h42);
        axi_read(4'h0, 5, d); chk("rx_bp", d, 32'h42);
        axi_write(4'h4, 32'h33, 4'h1, 0, 5, r); chk("bresp_bp", r, 2'b00);

        // Concurrent read and write
        rx_push(8'h81);
        p0 = tx_pushes;
        fork
            axi_read(4'h0, 0, d2);
            axi_write(4'h4, 32'h66, 4'h1, 0, 0, r2);
        join
        chk("conc_rdata", d2, 32'h81);
        chk("conc_bresp", r2, 2'b00);
        chk("conc_push", 32'(tx_pushes - p0), 32'd1);

        // Reset while in W_EXEC
        @(negedge clk);
        chk("pre_awready", awready, 1'b1);
        awaddr = 4'h4; wdata = 32'h99; wstrb = 4'h1; awvalid = 1; wvalid = 1; bready = 0;
        @(negedge clk);
        awvalid = 0; wvalid = 0; reset = 1;
        @(negedge clk);
        chk_reset_outputs("rst_wexec");
        reset = 0;
        repeat (4) begin @(negedge clk); chk("no_bvalid_after_rst", bvalid, 1'b0); end

        // Reset while in R_DATA
        rx_push(8'h5E);
        @(negedge clk);
        araddr = 4'h0; arvalid = 1; rready = 0;
        @(negedge clk);
        arvalid = 0;
        chk("rdata_phase", rvalid, 1'b1);
        reset = 1;
        @(negedge clk);
        chk_reset_outputs("rst_rdata");
        reset = 0;
        repeat (4) begin @(negedge clk); chk("no_rvalid_after_rst", rvalid, 1'b0); end
        axi_read(4'hC, 0, d); chk("ctrl_after_reset", d, 32'h0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
